// File: rtl/parking_gate_controller.sv
// parking_gate_controller
//
// Slot-occupancy sequencer for the parking lot. Holds the registered
// occupancy vector (bit i = 1 means slot i is free). It serves one entry or
// exit request at a time, with exit taking priority. An entry receives the
// highest-numbered free slot. After each granted transaction the gate is held
// open for GATE_OPEN_CYCLES cycles.
//
// Ports
//   clk              : single rising-edge clock
//   reset            : synchronous, active-high
//   entry_req        : level request from the entry sensor
//   exit_req         : level request from the exit sensor
//   exit_slot        : slot being vacated, valid while exit_req is high
//   entry_ack        : one-cycle pulse, entry granted
//   entry_full       : one-cycle pulse, entry refused because the lot is full
//   exit_ack         : one-cycle pulse, exit granted
//   exit_err         : one-cycle pulse, exit_slot was already free or out of range
//   park_number      : slot given to the last granted entry
//   parking_capacity : occupancy vector, 1 = free
//   free_count       : number of free slots
//   gate_open        : gate actuator drive
//   busy             : high whenever the controller is not idle
module parking_gate_controller #(
    parameter int SLOTS            = 8,
    parameter int GATE_OPEN_CYCLES = 4,
    localparam int SW              = $clog2(SLOTS),
    localparam int FW              = $clog2(SLOTS + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             entry_req,
    input  logic             exit_req,
    input  logic [SW-1:0]    exit_slot,
    output logic             entry_ack,
    output logic             entry_full,
    output logic             exit_ack,
    output logic             exit_err,
    output logic [SW-1:0]    park_number,
    output logic [SLOTS-1:0] parking_capacity,
    output logic [FW-1:0]    free_count,
    output logic             gate_open,
    output logic             busy
);

    localparam int TW = (GATE_OPEN_CYCLES > 1) ? $clog2(GATE_OPEN_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_LOAD = TW'(GATE_OPEN_CYCLES - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        GATE = 1'b1
    } state_t;

    state_t           state_reg, state_next;
    logic [TW-1:0]    timer_reg, timer_next;
    logic [SLOTS-1:0] cap_reg, cap_next;
    logic [SW-1:0]    park_reg, park_next;
    logic             entry_ack_reg, entry_ack_next;
    logic             entry_full_reg, entry_full_next;
    logic             exit_ack_reg, exit_ack_next;
    logic             exit_err_reg, exit_err_next;

    // Highest-free-slot selection. A slot is chosen when it is free and no
    // slot above it is free, which gives a one-hot select vector.
    logic [SLOTS-1:0] above_free;
    logic [SLOTS-1:0] sel_onehot;
    logic [SW-1:0]    sel_idx;
    logic             exit_slot_valid;
    logic             arbitrate;

    generate
        for (genvar gi = 0; gi < SLOTS; gi++) begin : g_sel
            if (gi == SLOTS - 1) begin : g_top
                assign above_free[gi] = 1'b0;
            end else begin : g_lower
                assign above_free[gi] = |cap_reg[SLOTS-1:gi+1];
            end
            assign sel_onehot[gi] = cap_reg[gi] & ~above_free[gi];
        end
    endgenerate

    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < SLOTS; i++) begin
            if (sel_onehot[i]) begin
                sel_idx = SW'(i);
            end
        end
    end

    always_comb begin
        free_count = '0;
        for (int i = 0; i < SLOTS; i++) begin
            free_count = free_count + FW'(cap_reg[i]);
        end
    end

    assign exit_slot_valid = (32'(exit_slot) < SLOTS);

    // The last gate cycle also serves as the arbitration slot. A request seen
    // at the edge that closes the gate is answered straight away, which keeps
    // the throughput at one grant per GATE_OPEN_CYCLES cycles.
    assign arbitrate = (state_reg == IDLE) || (timer_reg == '0);

    always_comb begin
        state_next      = state_reg;
        timer_next      = timer_reg;
        cap_next        = cap_reg;
        park_next       = park_reg;
        entry_ack_next  = 1'b0;
        entry_full_next = 1'b0;
        exit_ack_next   = 1'b0;
        exit_err_next   = 1'b0;

        if (state_reg == GATE) begin
            if (timer_reg != '0) begin
                timer_next = timer_reg - 1'b1;
            end else begin
                state_next = IDLE;
            end
        end

        if (arbitrate) begin
            if (exit_req) begin
                if (exit_slot_valid && !cap_reg[exit_slot]) begin
                    cap_next[exit_slot] = 1'b1;
                    exit_ack_next       = 1'b1;
                    state_next          = GATE;
                    timer_next          = TIMER_LOAD;
                end else begin
                    exit_err_next = 1'b1;
                end
            end else if (entry_req) begin
                if (|cap_reg) begin
                    cap_next[sel_idx] = 1'b0;
                    park_next         = sel_idx;
                    entry_ack_next    = 1'b1;
                    state_next        = GATE;
                    timer_next        = TIMER_LOAD;
                end else begin
                    entry_full_next = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            timer_reg      <= '0;
            cap_reg        <= '1;
            park_reg       <= '0;
            entry_ack_reg  <= 1'b0;
            entry_full_reg <= 1'b0;
            exit_ack_reg   <= 1'b0;
            exit_err_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            timer_reg      <= timer_next;
            cap_reg        <= cap_next;
            park_reg       <= park_next;
            entry_ack_reg  <= entry_ack_next;
            entry_full_reg <= entry_full_next;
            exit_ack_reg   <= exit_ack_next;
            exit_err_reg   <= exit_err_next;
        end
    end

    assign entry_ack        = entry_ack_reg;
    assign entry_full       = entry_full_reg;
    assign exit_ack         = exit_ack_reg;
    assign exit_err         = exit_err_reg;
    assign park_number      = park_reg;
    assign parking_capacity = cap_reg;
    assign gate_open        = (state_reg == GATE);
    assign busy             = (state_reg != IDLE);

endmodule

// File: tb/tb_parking_gate_controller.sv
// Self-checking bench for parking_gate_controller (SLOTS=8, GATE_OPEN_CYCLES=4).
// Expected responses are pushed to a scoreboard queue when a request is
// driven, and they are popped when the controller pulses a response.
module tb_parking_gate_controller;

    localparam int G = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       entry_req = 1'b0;
    logic       exit_req = 1'b0;
    logic [2:0] exit_slot = 3'd0;
    logic       entry_ack, entry_full, exit_ack, exit_err;
    logic [2:0] park_number;
    logic [7:0] parking_capacity;
    logic [3:0] free_count;
    logic       gate_open, busy;

    int checks = 0;
    int errors = 0;

    parking_gate_controller #(
        .SLOTS            (8),
        .GATE_OPEN_CYCLES (G)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .entry_req        (entry_req),
        .exit_req         (exit_req),
        .exit_slot        (exit_slot),
        .entry_ack        (entry_ack),
        .entry_full       (entry_full),
        .exit_ack         (exit_ack),
        .exit_err         (exit_err),
        .park_number      (park_number),
        .parking_capacity (parking_capacity),
        .free_count       (free_count),
        .gate_open        (gate_open),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    // pulses: {entry_ack, entry_full, exit_ack, exit_err}
    typedef struct packed {
        logic [3:0] pulses;
        logic [2:0] park;
        logic [7:0] cap;
    } exp_t;

    typedef struct packed {
        logic [3:0] pulses;
        logic [2:0] park;
        logic [7:0] cap;
        logic [3:0] fc;
        logic       gate;
        logic       busy;
    } rsp_t;

    exp_t       sb[$];
    logic [7:0] model_cap = 8'hFF;
    logic [2:0] model_park = 3'd0;

    function automatic logic [3:0] count_ones(input logic [7:0] v);
        logic [3:0] c = 4'd0;
        for (int i = 0; i < 8; i++) c = c + {3'd0, v[i]};
        return c;
    endfunction

    // Reference behaviour: compute the expected response and push it
    function automatic void predict(input bit e, input bit x, input logic [2:0] slot);
        exp_t ex;
        ex.pulses = 4'b0000;
        if (x) begin
            if (!model_cap[slot]) begin
                model_cap[slot] = 1'b1;
                ex.pulses = 4'b0010;
            end else begin
                ex.pulses = 4'b0001;
            end
        end else if (e) begin
            if (model_cap != 8'h00) begin
                for (int i = 7; i >= 0; i--) begin
                    if (model_cap[i]) begin
                        model_park = 3'(i);
                        break;
                    end
                end
                model_cap[model_park] = 1'b0;
                ex.pulses = 4'b1000;
            end else begin
                ex.pulses = 4'b0100;
            end
        end
        ex.park = model_park;
        ex.cap  = model_cap;
        sb.push_back(ex);
    endfunction

    task automatic send(input bit e, input bit x, input logic [2:0] slot);
        @(negedge clk);
        entry_req = e;
        exit_req  = x;
        exit_slot = slot;
        predict(e, x, slot);
    endtask

    task automatic release_req();
        entry_req = 1'b0;
        exit_req  = 1'b0;
    endtask

    // Wait (bounded) for any response pulse; lat counts negedges waited
    task automatic await_resp(output rsp_t r, output int lat);
        r = '0;
        lat = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            lat++;
            if ({entry_ack, entry_full, exit_ack, exit_err} != 4'b0000) begin
                r.pulses = {entry_ack, entry_full, exit_ack, exit_err};
                r.park   = park_number;
                r.cap    = parking_capacity;
                r.fc     = free_count;
                r.gate   = gate_open;
                r.busy   = busy;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL response_timeout got none required a pulse within 20 cycles");
        lat = -1;
    endtask

    task automatic take_exp(output exp_t ex);
        ex = '0;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty got empty queue required an expectation");
        end else begin
            ex = sb.pop_front();
        end
    endtask

    // Count gate_open cycles from the current negedge on (bounded)
    task automatic wait_gate(output int n);
        n = 0;
        while (gate_open && n < 50) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        release_req();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_cap  = 8'hFF;
        model_park = 3'd0;
        sb.delete();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (parking_capacity !== 8'hFF) begin errors++; $display("FAIL reset_cap got %h required ff", parking_capacity); end
        checks++; if (free_count !== 4'd8) begin errors++; $display("FAIL reset_free_count got %0d required 8", free_count); end
        checks++; if (park_number !== 3'd0) begin errors++; $display("FAIL reset_park got %0d required 0", park_number); end
        checks++; if ({gate_open, busy} !== 2'b00) begin errors++; $display("FAIL reset_gate_busy got %b required 00", {gate_open, busy}); end
        checks++; if ({entry_ack, entry_full, exit_ack, exit_err} !== 4'b0000) begin errors++; $display("FAIL reset_pulses got %b required 0000", {entry_ack, entry_full, exit_ack, exit_err}); end
        $display("txn reset: cap=%h free=%0d", parking_capacity, free_count);
    endtask

    task automatic test_entry();
        rsp_t r; exp_t ex; int lat; int n;
        send(1'b1, 1'b0, 3'd0);
        await_resp(r, lat);
        take_exp(ex);
        release_req();
        checks++; if (r.pulses !== ex.pulses) begin errors++; $display("FAIL entry_pulses got %b required %b", r.pulses, ex.pulses); end
        checks++; if (r.park !== 3'd7) begin errors++; $display("FAIL entry_park got %0d required 7", r.park); end
        checks++; if (r.cap !== ex.cap) begin errors++; $display("FAIL entry_cap got %h required %h", r.cap, ex.cap); end
        checks++; if (r.fc !== 4'd7) begin errors++; $display("FAIL entry_free_count got %0d required 7", r.fc); end
        checks++; if (lat != 1) begin errors++; $display("FAIL entry_latency got %0d required 1", lat); end
        wait_gate(n);
        checks++; if (n != G) begin errors++; $display("FAIL entry_gate_cycles got %0d required %0d", n, G); end
        $display("txn entry: park=%0d cap=%h lat=%0d gate=%0d", r.park, r.cap, lat, n);
    endtask

    task automatic test_fill();
        rsp_t r; exp_t ex; int lat; int n;
        do_reset();
        for (int k = 0; k < 8; k++) begin
            send(1'b1, 1'b0, 3'd0);
            await_resp(r, lat);
            take_exp(ex);
            release_req();
            checks++; if (r.pulses !== ex.pulses) begin errors++; $display("FAIL fill_pulses[%0d] got %b required %b", k, r.pulses, ex.pulses); end
            checks++; if (r.park !== 3'(7 - k)) begin errors++; $display("FAIL fill_park[%0d] got %0d required %0d", k, r.park, 7 - k); end
            checks++; if (r.cap !== ex.cap || r.fc !== count_ones(ex.cap)) begin errors++; $display("FAIL fill_cap[%0d] got %h/%0d required %h/%0d", k, r.cap, r.fc, ex.cap, count_ones(ex.cap)); end
            wait_gate(n);
            checks++; if (n != G) begin errors++; $display("FAIL fill_gate[%0d] got %0d required %0d", k, n, G); end
            $display("txn fill %0d: park=%0d cap=%h", k, r.park, r.cap);
        end
        send(1'b1, 1'b0, 3'd0);
        await_resp(r, lat);
        take_exp(ex);
        release_req();
        checks++; if (r.pulses !== 4'b0100) begin errors++; $display("FAIL full_pulses got %b required 0100", r.pulses); end
        checks++; if (r.cap !== 8'h00 || r.fc !== 4'd0) begin errors++; $display("FAIL full_cap got %h/%0d required 00/0", r.cap, r.fc); end
        checks++; if ({r.gate, r.busy} !== 2'b00) begin errors++; $display("FAIL full_gate_busy got %b required 00", {r.gate, r.busy}); end
        @(negedge clk);
        checks++; if (gate_open !== 1'b0 || parking_capacity !== 8'h00) begin errors++; $display("FAIL full_after got gate=%b cap=%h required gate=0 cap=00", gate_open, parking_capacity); end
        $display("txn entry_full: cap=%h", r.cap);
    endtask

    task automatic test_exit_reuse();
        rsp_t r; exp_t ex; int lat; int n;
        send(1'b0, 1'b1, 3'd3);
        await_resp(r, lat);
        take_exp(ex);
        release_req();
        checks++; if (r.pulses !== 4'b0010) begin errors++; $display("FAIL exit_pulses got %b required 0010", r.pulses); end
        checks++; if (r.cap !== 8'h08 || r.cap !== ex.cap) begin errors++; $display("FAIL exit_cap got %h required 08", r.cap); end
        checks++; if (lat != 1) begin errors++; $display("FAIL exit_latency got %0d required 1", lat); end
        wait_gate(n);
        checks++; if (n != G) begin errors++; $display("FAIL exit_gate got %0d required %0d", n, G); end
        $display("txn exit slot3: cap=%h", r.cap);
        send(1'b1, 1'b0, 3'd0);
        await_resp(r, lat);
        take_exp(ex);
        release_req();
        checks++; if (r.pulses !== ex.pulses || r.park !== 3'd3) begin errors++; $display("FAIL reuse_park got %b/%0d required %b/3", r.pulses, r.park, ex.pulses); end
        checks++; if (r.cap !== 8'h00) begin errors++; $display("FAIL reuse_cap got %h required 00", r.cap); end
        wait_gate(n);
        $display("txn reuse: park=%0d cap=%h", r.park, r.cap);
    endtask

    task automatic test_invalid_exit();
        rsp_t r; exp_t ex; int lat;
        do_reset();
        send(1'b0, 1'b1, 3'd5);
        await_resp(r, lat);
        take_exp(ex);
        release_req();
        checks++; if (r.pulses !== ex.pulses || r.pulses !== 4'b0001) begin errors++; $display("FAIL exit_err_pulses got %b required 0001", r.pulses); end
        checks++; if (r.cap !== 8'hFF) begin errors++; $display("FAIL exit_err_cap got %h required ff", r.cap); end
        checks++; if ({r.gate, r.busy} !== 2'b00) begin errors++; $display("FAIL exit_err_busy got %b required 00", {r.gate, r.busy}); end
        $display("txn exit_err slot5: cap=%h", r.cap);
    endtask

    task automatic test_simultaneous();
        rsp_t r; exp_t ex; int lat; int n;
        do_reset();
        send(1'b1, 1'b0, 3'd0);
        await_resp(r, lat);
        take_exp(ex);
        release_req();
        wait_gate(n);
        checks++; if (r.cap !== 8'h7F) begin errors++; $display("FAIL sim_setup_cap got %h required 7f", r.cap); end
        send(1'b1, 1'b1, 3'd7);
        await_resp(r, lat);
        take_exp(ex);
        exit_req = 1'b0;
        predict(1'b1, 1'b0, 3'd0);
        checks++; if (r.pulses !== 4'b0010 || r.pulses !== ex.pulses) begin errors++; $display("FAIL sim_exit_first got %b required 0010", r.pulses); end
        checks++; if (r.cap !== 8'hFF) begin errors++; $display("FAIL sim_exit_cap got %h required ff", r.cap); end
        $display("txn sim exit: cap=%h lat=%0d", r.cap, lat);
        await_resp(r, lat);
        take_exp(ex);
        release_req();
        checks++; if (r.pulses !== ex.pulses || r.park !== 3'd7) begin errors++; $display("FAIL sim_entry got %b/%0d required %b/7", r.pulses, r.park, ex.pulses); end
        checks++; if (r.cap !== 8'h7F) begin errors++; $display("FAIL sim_entry_cap got %h required 7f", r.cap); end
        checks++; if (lat != G) begin errors++; $display("FAIL sim_entry_latency got %0d required %0d", lat, G); end
        wait_gate(n);
        checks++; if (n != G) begin errors++; $display("FAIL sim_entry_gate got %0d required %0d", n, G); end
        $display("txn sim entry: park=%0d cap=%h lat=%0d", r.park, r.cap, lat);
    endtask

    task automatic test_reset_mid_gate();
        rsp_t r; exp_t ex; int lat;
        send(1'b1, 1'b0, 3'd0);
        await_resp(r, lat);
        take_exp(ex);
        release_req();
        checks++; if (r.pulses !== ex.pulses || r.cap !== 8'h3F) begin errors++; $display("FAIL mid_setup got %b/%h required %b/3f", r.pulses, r.cap, ex.pulses); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++; if ({gate_open, busy} !== 2'b00) begin errors++; $display("FAIL mid_reset_gate got %b required 00", {gate_open, busy}); end
        checks++; if (parking_capacity !== 8'hFF || free_count !== 4'd8) begin errors++; $display("FAIL mid_reset_cap got %h/%0d required ff/8", parking_capacity, free_count); end
        checks++; if ({entry_ack, entry_full, exit_ack, exit_err} !== 4'b0000) begin errors++; $display("FAIL mid_reset_pulses got %b required 0000", {entry_ack, entry_full, exit_ack, exit_err}); end
        reset = 1'b0;
        model_cap  = 8'hFF;
        model_park = 3'd0;
        $display("txn reset mid-gate: gate=%b cap=%h", gate_open, parking_capacity);
    endtask

    initial begin
        test_reset();
        test_entry();
        test_fill();
        test_exit_reuse();
        test_invalid_exit();
        test_simultaneous();
        test_reset_mid_gate();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover got %0d entries required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
